// File: rtl/toggle_event_rx_if.sv
// Event drain port of toggle_event_rx: valid/ready handshake plus pending depth.
// Latency: n/a (wires only).
// Backpressure: consumer holds ev_ready low to leave events pending.
//
// Signals:
//   ev_valid  producer -> consumer  at least one event pending
//   ev_ready  consumer -> producer  accept one event when ev_valid=1
//   pend_cnt  producer -> consumer  number of pending events (PW bits)
interface toggle_event_rx_if #(
   parameter int PW = 3
);
   logic          ev_valid;
   logic          ev_ready;
   logic [PW-1:0] pend_cnt;

   modport master (
      output ev_valid,
      output pend_cnt,
      input  ev_ready
   );

   modport slave (
      input  ev_valid,
      input  pend_cnt,
      output ev_ready
   );
endinterface

// File: rtl/toggle_event_rx.sv
// Receives a toggle-encoded event line, recovers one pulse per level change, queues pending events.
// Latency: t_in edge to ev_pulse is SYNC_STAGES+1 clk (SYNC_STAGES+2 with the glitch filter).
// Backpressure: ev_ready low lets events accumulate up to MAX_PEND; beyond that they drop and set overflow.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   t_in      toggle line from the sender, asynchronous to clk
//   ev_pulse  one-cycle pulse per detected toggle (registered)
//   ev_if     master side: ev_valid (decoded from state), ev_ready, pend_cnt
//   ev_total  free-running count of detected events, wraps at 2^CNT_W
//   overflow  sticky, set when an event arrives while FULL and not popped
//   ovf_clr   clears overflow next cycle (a simultaneous new overflow wins)
//   t_level   synchronised level of t_in
//
// Optional: define TOGGLE_RX_GLITCH_FILTER_EN to add one more sample stage after t_level
// and accept a change only when the last two samples agree; single-cycle glitches vanish.
module toggle_event_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_PEND    = 7,
   parameter int PW          = 3,
   parameter int CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   t_in,
   output logic                   ev_pulse,
   toggle_event_rx_if.master      ev_if,
   output logic [CNT_W-1:0]       ev_total,
   output logic                   overflow,
   input  logic                   ovf_clr,
   output logic                   t_level
);

`ifdef TOGGLE_RX_GLITCH_FILTER_EN
   localparam int PRIME_LEN = SYNC_STAGES + 2;
`else
   localparam int PRIME_LEN = SYNC_STAGES + 1;
`endif

   localparam logic [PW-1:0] MAXP = PW'(MAX_PEND);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_PART  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Synchroniser chain; t_level is the last stage.
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], t_in};
      end
   end

   assign t_level = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Prime counter: after reset the chain still holds zeros while the
   // real line level propagates in. prev just follows the line during
   // this window so a level held through reset is not taken as an event.
   // ------------------------------------------------------------------
   logic [2:0] prime_cnt;
   logic       prime_done;

   assign prime_done = (prime_cnt == 3'(PRIME_LEN));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prime_cnt <= '0;
      end else if (!prime_done) begin
         prime_cnt <= prime_cnt + 3'd1;
      end
   end

   // ------------------------------------------------------------------
   // Edge detect.
   // ------------------------------------------------------------------
   logic prev_q;
   logic det;

`ifdef TOGGLE_RX_GLITCH_FILTER_EN
   logic filt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt_q <= 1'b0;
      end else begin
         filt_q <= t_level;
      end
   end

   // Two agreeing samples that differ from the accepted level form an
   // event. prev only moves on acceptance, otherwise a glitch would be
   // tracked into prev and the return edge would look like a change.
   assign det = prime_done && (t_level == filt_q) && (filt_q != prev_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q <= 1'b0;
      end else if (!prime_done || det) begin
         prev_q <= filt_q;
      end
   end
`else
   assign det = prime_done && (t_level != prev_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= t_level;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ev_pulse <= 1'b0;
      end else begin
         ev_pulse <= det;
      end
   end

   // ------------------------------------------------------------------
   // Event total, independent of pending saturation.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ev_total <= '0;
      end else if (det) begin
         ev_total <= ev_total + CNT_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Pending-event state machine.
   // ------------------------------------------------------------------
   state_t        state_q, state_nxt;
   logic [PW-1:0] pend_q, pend_nxt;
   logic          ovf_set;
   logic          pop;

   assign ev_if.ev_valid = (state_q != ST_EMPTY);
   assign ev_if.pend_cnt = pend_q;
   assign pop            = ev_if.ev_valid && ev_if.ev_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_EMPTY;
         pend_q  <= '0;
      end else begin
         state_q <= state_nxt;
         pend_q  <= pend_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      pend_nxt  = pend_q;
      ovf_set   = 1'b0;
      unique case (state_q)
         ST_EMPTY: begin
            // pop cannot occur here: ev_valid is low, ev_ready is ignored
            if (det) begin
               pend_nxt  = pend_q + PW'(1);
               state_nxt = (pend_nxt == MAXP) ? ST_FULL : ST_PART;
            end
         end
         ST_PART: begin
            if (det && !pop) begin
               pend_nxt  = pend_q + PW'(1);
               state_nxt = (pend_nxt == MAXP) ? ST_FULL : ST_PART;
            end else if (pop && !det) begin
               pend_nxt  = pend_q - PW'(1);
               state_nxt = (pend_nxt == '0) ? ST_EMPTY : ST_PART;
            end
         end
         ST_FULL: begin
            // det with a simultaneous pop replaces the popped slot: no loss
            if (det && !pop) begin
               ovf_set = 1'b1;
            end else if (pop && !det) begin
               pend_nxt  = pend_q - PW'(1);
               state_nxt = (pend_nxt == '0) ? ST_EMPTY : ST_PART;
            end
         end
         default: begin
            state_nxt = ST_EMPTY;
            pend_nxt  = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Sticky overflow; a new loss outranks a clear in the same cycle.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
      end else if (ovf_set) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_toggle_event_rx.sv
// Bench for toggle_event_rx: scoreboard of expected pulse cycle / running total per toggle.
// Latency: pulses are expected LAT cycles after each toggle is driven.
// Backpressure: ev_ready is driven directly to exercise saturation, pops and collisions.
module tb_toggle_event_rx;

   localparam int SYNC_STAGES = 2;
   localparam int MAX_PEND    = 7;
   localparam int PW          = 3;
   localparam int CNT_W       = 4;
`ifdef TOGGLE_RX_GLITCH_FILTER_EN
   localparam int LAT = SYNC_STAGES + 2;
`else
   localparam int LAT = SYNC_STAGES + 1;
`endif

   typedef struct packed {
      logic [31:0]      cyc;
      logic [CNT_W-1:0] tot;
   } sb_entry_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             t_in;
   logic             ev_pulse;
   logic [CNT_W-1:0] ev_total;
   logic             overflow;
   logic             ovf_clr;
   logic             t_level;

   int               checks = 0;
   int               errors = 0;
   logic [31:0]      cyc = 0;
   logic [CNT_W-1:0] exp_total;
   sb_entry_t        sb[$];
   sb_entry_t        mon_e;

   toggle_event_rx_if #(.PW(PW)) ev_if ();

   toggle_event_rx #(
      .SYNC_STAGES (SYNC_STAGES),
      .MAX_PEND    (MAX_PEND),
      .PW          (PW),
      .CNT_W       (CNT_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .t_in     (t_in),
      .ev_pulse (ev_pulse),
      .ev_if    (ev_if),
      .ev_total (ev_total),
      .overflow (overflow),
      .ovf_clr  (ovf_clr),
      .t_level  (t_level)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge: the next posedge samples the new level.
   task automatic toggle_ev();
      t_in      = ~t_in;
      exp_total = exp_total + 1'b1;
      sb.push_back('{cyc: cyc + LAT, tot: exp_total});
   endtask

   // Every pulse must match the oldest outstanding toggle in time and total.
   always @(negedge clk) begin
      if (reset && ev_pulse) begin
         if (sb.size() == 0) begin
            check("unexp_pulse", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("pulse_cyc", cyc, mon_e.cyc);
            check("pulse_total", 32'(ev_total), 32'(mon_e.tot));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset           = 1'b0;
      t_in            = 1'b1;
      ovf_clr         = 1'b0;
      ev_if.ev_ready  = 1'b0;
      exp_total       = '0;

      // Reset state, line held high through reset.
      wait_n(3);
      check("rst_pulse", 32'(ev_pulse), 0);
      check("rst_valid", 32'(ev_if.ev_valid), 0);
      check("rst_tlevel", 32'(t_level), 0);
      reset = 1'b1;
      wait_n(20);
      check("prime_pend", 32'(ev_if.pend_cnt), 0);
      check("prime_total", 32'(ev_total), 0);
      check("prime_tlevel", 32'(t_level), 1);
      check("prime_valid", 32'(ev_if.ev_valid), 0);

      // Single toggle.
      toggle_ev();
      wait_n(4);
      check("one_pend", 32'(ev_if.pend_cnt), 1);
      check("one_valid", 32'(ev_if.ev_valid), 1);
      check("one_total", 32'(ev_total), 1);

      // Fill to MAX_PEND, then one more overflows.
      for (int i = 0; i < 6; i++) begin
         toggle_ev();
         wait_n(4);
      end
      check("full_pend", 32'(ev_if.pend_cnt), 7);
      check("full_no_ovf", 32'(overflow), 0);
      toggle_ev();
      wait_n(4);
      check("ovf_pend", 32'(ev_if.pend_cnt), 7);
      check("ovf_set", 32'(overflow), 1);
      check("ovf_total", 32'(ev_total), 8);

      // Clear overflow.
      ovf_clr = 1'b1;
      wait_n(1);
      ovf_clr = 1'b0;
      check("ovf_clr", 32'(overflow), 0);

      // det and pop in the same cycle while FULL.
      toggle_ev();
      wait_n(2);
      ev_if.ev_ready = 1'b1;
      wait_n(1);
      ev_if.ev_ready = 1'b0;
      check("detpop_pend", 32'(ev_if.pend_cnt), 7);
      check("detpop_ovf", 32'(overflow), 0);
      wait_n(2);

      // New overflow coinciding with ovf_clr wins.
      toggle_ev();
      wait_n(2);
      ovf_clr = 1'b1;
      wait_n(1);
      ovf_clr = 1'b0;
      check("ovf_win", 32'(overflow), 1);
      wait_n(2);
      check("ovf_sticky", 32'(overflow), 1);
      check("ovf_total2", 32'(ev_total), 10);
      ovf_clr = 1'b1;
      wait_n(1);
      ovf_clr = 1'b0;
      check("ovf_clr2", 32'(overflow), 0);

      // Drain: seven pops, then ready while EMPTY is ignored.
      ev_if.ev_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         check("drain_valid", 32'(ev_if.ev_valid), 1);
         wait_n(1);
         check("drain_pend", 32'(ev_if.pend_cnt), 32'(6 - i));
      end
      check("empty_valid", 32'(ev_if.ev_valid), 0);
      wait_n(2);
      check("empty_pend", 32'(ev_if.pend_cnt), 0);
      ev_if.ev_ready = 1'b0;

      // Total wrap with a fresh reset: 17 events modulo 16 -> 1.
      reset = 1'b0;
      wait_n(2);
      reset = 1'b1;
      sb.delete();
      exp_total = '0;
      wait_n(6);
      ev_if.ev_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         toggle_ev();
         wait_n(4);
      end
      check("wrap_total", 32'(ev_total), 1);
      check("wrap_pend", 32'(ev_if.pend_cnt), 0);
      check("wrap_ovf", 32'(overflow), 0);
      ev_if.ev_ready = 1'b0;

      // Reset mid-burst with three pending and one toggle in flight.
      for (int i = 0; i < 3; i++) begin
         toggle_ev();
         wait_n(4);
      end
      check("burst_pend", 32'(ev_if.pend_cnt), 3);
      toggle_ev();
      wait_n(1);
      #2;
      reset = 1'b0;
      #1;
      sb.delete();
      check("mid_pulse", 32'(ev_pulse), 0);
      check("mid_valid", 32'(ev_if.ev_valid), 0);
      check("mid_pend", 32'(ev_if.pend_cnt), 0);
      check("mid_total", 32'(ev_total), 0);
      check("mid_ovf", 32'(overflow), 0);
      check("mid_tlevel", 32'(t_level), 0);
      exp_total = '0;
      wait_n(2);
      reset = 1'b1;
      wait_n(10);
      check("post_pend", 32'(ev_if.pend_cnt), 0);
      check("post_total", 32'(ev_total), 0);

`ifdef TOGGLE_RX_GLITCH_FILTER_EN
      // One-cycle glitch is filtered; a stable change yields one event.
      t_in = ~t_in;
      wait_n(1);
      t_in = ~t_in;
      wait_n(8);
      check("glitch_total", 32'(ev_total), 0);
      toggle_ev();
      wait_n(6);
      check("filt_total", 32'(ev_total), 1);
`endif

      check("sb_drain", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
